// File: rtl/id_ex_latch_pkg.sv
// id_ex_latch_pkg
//   Shared definitions for the ID/EX pipeline latch: field widths, the NOP
//   opcode, the stall-run limit that flags an illegal stall, and the bundle
//   of fields that travels from ID into EX.
//   Optional feature macro used by the block: PERF_STALL_COUNT_EN.
package id_ex_latch_pkg;

  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int WORD_W   = 32;

  localparam logic [OPCODE_W-1:0] OP_NOP = '0;

  // A load-use stall may last one cycle; a run of two is already illegal.
  localparam logic [1:0] STALL_ERR_RUN = 2'd2;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    dest;
    logic [WORD_W-1:0]   rs_val;
    logic [WORD_W-1:0]   rt_val;
    logic [WORD_W-1:0]   imm;
    logic [WORD_W-1:0]   pc;
    logic                valid;
  } ex_fields_t;

  // Bubble: NOP with dest 0 so no downstream forward unit can match it.
  function automatic ex_fields_t bubble();
    ex_fields_t b;
    b        = '0;
    b.opcode = OP_NOP;
    b.dest   = '0;
    b.valid  = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_latch_stall_monitor.sv
// stall_monitor
//   Watches the hold_id request and flags stalls that run longer than the
//   pipeline allows. Optionally keeps performance counters.
//   Ports:
//     clk, rst        pipeline clock, synchronous active-high reset
//     hold_id         1 when IF/ID is frozen this cycle
//     stall_err       sticky flag, set when a stall run reaches the limit
//   With PERF_STALL_COUNT_EN defined:
//     flush           squash indication from EX
//     stall_cycles    count of cycles with hold_id = 1 (wraps at 2^32)
//     bubbles_flush   count of flush cycles (wraps at 2^32)
module stall_monitor
  import id_ex_latch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hold_id,
`ifdef PERF_STALL_COUNT_EN
  input  logic              flush,
  output logic [WORD_W-1:0] stall_cycles,
  output logic [WORD_W-1:0] bubbles_flush,
`endif
  output logic              stall_err
);

  logic [1:0] stall_run_d, stall_run_q;
  logic       stall_err_d, stall_err_q;
`ifdef PERF_STALL_COUNT_EN
  logic [WORD_W-1:0] stall_cycles_d, stall_cycles_q;
  logic [WORD_W-1:0] bubbles_flush_d, bubbles_flush_q;
`endif

  always_comb begin
    stall_run_d = 2'd0;
    if (hold_id) begin
      stall_run_d = (stall_run_q == 2'd3) ? 2'd3 : stall_run_q + 2'd1;
    end
    // The error latches on the same edge the run counter reaches the limit.
    stall_err_d = stall_err_q | (stall_run_d >= STALL_ERR_RUN);
`ifdef PERF_STALL_COUNT_EN
    stall_cycles_d  = hold_id ? stall_cycles_q + 32'd1 : stall_cycles_q;
    bubbles_flush_d = flush ? bubbles_flush_q + 32'd1 : bubbles_flush_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_run_q <= 2'd0;
      stall_err_q <= 1'b0;
`ifdef PERF_STALL_COUNT_EN
      stall_cycles_q  <= '0;
      bubbles_flush_q <= '0;
`endif
    end else begin
      stall_run_q <= stall_run_d;
      stall_err_q <= stall_err_d;
`ifdef PERF_STALL_COUNT_EN
      stall_cycles_q  <= stall_cycles_d;
      bubbles_flush_q <= bubbles_flush_d;
`endif
    end
  end

  assign stall_err = stall_err_q;
`ifdef PERF_STALL_COUNT_EN
  assign stall_cycles  = stall_cycles_q;
  assign bubbles_flush = bubbles_flush_q;
`endif

endmodule

// File: rtl/id_ex_latch.sv
// id_ex_latch
//   ID/EX pipeline register with flush and load-use stall handling.
//   Edge priority: rst > flush > stall request > capture. Flush and stall
//   both load a bubble into EX; only a stall without flush holds IF/ID.
//   Ports:
//     clk, rst                  pipeline clock, synchronous active-high reset
//     id_opcode/dest/rs_val/rt_val/imm/pc   fields of the ID instruction
//     id_rs_stall, id_rt_stall  load-use stall requests from forward units
//     flush                     redirect resolved in EX, squashes ID
//     ex_*                      registered EX-stage fields, ex_valid = real
//     hold_id                   combinational freeze for IF/ID and PC
//     stall_err                 sticky illegal-stall flag
//   Optional (macro PERF_STALL_COUNT_EN): stall_cycles, bubbles_flush.
module id_ex_latch
  import id_ex_latch_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [REG_W-1:0]    id_dest,
  input  logic [WORD_W-1:0]   id_rs_val,
  input  logic [WORD_W-1:0]   id_rt_val,
  input  logic                id_rs_stall,
  input  logic                id_rt_stall,
  input  logic [WORD_W-1:0]   id_imm,
  input  logic [WORD_W-1:0]   id_pc,
  input  logic                flush,
  output logic [OPCODE_W-1:0] ex_opcode,
  output logic [REG_W-1:0]    ex_dest,
  output logic [WORD_W-1:0]   ex_rs_val,
  output logic [WORD_W-1:0]   ex_rt_val,
  output logic [WORD_W-1:0]   ex_imm,
  output logic [WORD_W-1:0]   ex_pc,
  output logic                ex_valid,
  output logic                hold_id,
`ifdef PERF_STALL_COUNT_EN
  output logic [WORD_W-1:0]   stall_cycles,
  output logic [WORD_W-1:0]   bubbles_flush,
`endif
  output logic                stall_err
);

  logic       stall_req;
  ex_fields_t ex_d, ex_q;

  always_comb begin
    stall_req = id_rs_stall | id_rt_stall;
    // A flush discards the ID instruction, so there is nothing to hold.
    hold_id   = stall_req & ~flush;

    ex_d = bubble();
    if (!flush && !stall_req) begin
      ex_d.opcode = id_opcode;
      ex_d.dest   = id_dest;
      ex_d.rs_val = id_rs_val;
      ex_d.rt_val = id_rt_val;
      ex_d.imm    = id_imm;
      ex_d.pc     = id_pc;
      ex_d.valid  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= bubble();
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_opcode = ex_q.opcode;
  assign ex_dest   = ex_q.dest;
  assign ex_rs_val = ex_q.rs_val;
  assign ex_rt_val = ex_q.rt_val;
  assign ex_imm    = ex_q.imm;
  assign ex_pc     = ex_q.pc;
  assign ex_valid  = ex_q.valid;

  stall_monitor u_stall_monitor (
    .clk           (clk),
    .rst           (rst),
    .hold_id       (hold_id),
`ifdef PERF_STALL_COUNT_EN
    .flush         (flush),
    .stall_cycles  (stall_cycles),
    .bubbles_flush (bubbles_flush),
`endif
    .stall_err     (stall_err)
  );

endmodule

// File: tb/tb_id_ex_latch.sv
// tb_id_ex_latch
//   Directed self-checking bench for id_ex_latch. Each task drives one
//   scenario and compares outputs against hand-computed values.
//   Honours PERF_STALL_COUNT_EN when defined.
module tb_id_ex_latch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  id_opcode;
  logic [4:0]  id_dest;
  logic [31:0] id_rs_val, id_rt_val, id_imm, id_pc;
  logic        id_rs_stall, id_rt_stall, flush;
  logic [5:0]  ex_opcode;
  logic [4:0]  ex_dest;
  logic [31:0] ex_rs_val, ex_rt_val, ex_imm, ex_pc;
  logic        ex_valid, hold_id, stall_err;
`ifdef PERF_STALL_COUNT_EN
  logic [31:0] stall_cycles, bubbles_flush;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  id_ex_latch dut (
    .clk           (clk),
    .rst           (rst),
    .id_opcode     (id_opcode),
    .id_dest       (id_dest),
    .id_rs_val     (id_rs_val),
    .id_rt_val     (id_rt_val),
    .id_rs_stall   (id_rs_stall),
    .id_rt_stall   (id_rt_stall),
    .id_imm        (id_imm),
    .id_pc         (id_pc),
    .flush         (flush),
    .ex_opcode     (ex_opcode),
    .ex_dest       (ex_dest),
    .ex_rs_val     (ex_rs_val),
    .ex_rt_val     (ex_rt_val),
    .ex_imm        (ex_imm),
    .ex_pc         (ex_pc),
    .ex_valid      (ex_valid),
    .hold_id       (hold_id),
`ifdef PERF_STALL_COUNT_EN
    .stall_cycles  (stall_cycles),
    .bubbles_flush (bubbles_flush),
`endif
    .stall_err     (stall_err)
  );

  // Advance one edge and settle past it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [5:0] op, input logic [4:0] dst,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] imm, input logic [31:0] pc);
    id_opcode = op; id_dest = dst; id_rs_val = rs;
    id_rt_val = rt; id_imm = imm;  id_pc = pc;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; id_rs_stall = 1'b0; id_rt_stall = 1'b0;
    set_id(6'd9, 5'd4, 32'hAAAA_5555, 32'h1234_5678, 32'hFFFF_FFFC, 32'h0040_0000);
    tick();
    tick();
    tests_run++;
    if (ex_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", ex_valid); end
    tests_run++;
    if (ex_opcode !== 6'd0 || ex_dest !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_opdest: got %0d/%0d expected 0/0", ex_opcode, ex_dest); end
    tests_run++;
    if (ex_rs_val !== 32'd0 || ex_rt_val !== 32'd0 || ex_imm !== 32'd0 || ex_pc !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_values: got %h %h %h %h expected zeros", ex_rs_val, ex_rt_val, ex_imm, ex_pc); end
    tests_run++;
    if (stall_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %b expected 0", stall_err); end
    rst = 1'b0;
  endtask

  task automatic test_capture();
    set_id(6'd3, 5'd31, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFF0, 32'h0040_0010);
    #1;
    tests_run++;
    if (hold_id !== 1'b0) begin tests_failed++; $display("[TB] FAIL capture_hold: got %b expected 0", hold_id); end
    tick();
    tests_run++;
    if (ex_opcode !== 6'd3 || ex_dest !== 5'd31) begin tests_failed++; $display("[TB] FAIL capture_opdest: got %0d/%0d expected 3/31", ex_opcode, ex_dest); end
    tests_run++;
    if (ex_pc !== 32'h0040_0010 || ex_imm !== 32'hFFFF_FFF0) begin tests_failed++; $display("[TB] FAIL capture_pcimm: got %h/%h expected 00400010/fffffff0", ex_pc, ex_imm); end
    tests_run++;
    if (ex_rs_val !== 32'h1111_1111 || ex_rt_val !== 32'h2222_2222) begin tests_failed++; $display("[TB] FAIL capture_operands: got %h/%h expected 11111111/22222222", ex_rs_val, ex_rt_val); end
    tests_run++;
    if (ex_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL capture_valid: got %b expected 1", ex_valid); end
  endtask

  task automatic test_back_to_back();
    set_id(6'd12, 5'd8, 32'h0000_00A0, 32'h0000_00B0, 32'h0000_0004, 32'h0040_0020);
    tick();
    set_id(6'd13, 5'd9, 32'h0000_00C0, 32'h0000_00D0, 32'h0000_0008, 32'h0040_0024);
    tests_run++;
    if (ex_opcode !== 6'd12 || ex_dest !== 5'd8 || ex_pc !== 32'h0040_0020 || ex_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_first: got op %0d dest %0d pc %h v %b expected 12/8/00400020/1", ex_opcode, ex_dest, ex_pc, ex_valid); end
    tick();
    tests_run++;
    if (ex_opcode !== 6'd13 || ex_dest !== 5'd9 || ex_rt_val !== 32'h0000_00D0 || ex_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_second: got op %0d dest %0d rt %h v %b expected 13/9/000000d0/1", ex_opcode, ex_dest, ex_rt_val, ex_valid); end
  endtask

  task automatic test_load_use();
    set_id(6'd5, 5'd7, 32'h0000_0101, 32'h0000_0202, 32'h0000_0010, 32'h0040_0014);
    id_rs_stall = 1'b1;
    #1;
    tests_run++;
    if (hold_id !== 1'b1) begin tests_failed++; $display("[TB] FAIL loaduse_hold: got %b expected 1", hold_id); end
    tick();
    tests_run++;
    if (ex_valid !== 1'b0 || ex_dest !== 5'd0 || ex_opcode !== 6'd0 || ex_rs_val !== 32'd0) begin tests_failed++; $display("[TB] FAIL loaduse_bubble: got v %b dest %0d op %0d rs %h expected 0/0/0/0", ex_valid, ex_dest, ex_opcode, ex_rs_val); end
    id_rs_stall = 1'b0;
    #1;
    tests_run++;
    if (hold_id !== 1'b0) begin tests_failed++; $display("[TB] FAIL loaduse_release: got %b expected 0", hold_id); end
    tick();
    tests_run++;
    if (ex_valid !== 1'b1 || ex_dest !== 5'd7 || ex_opcode !== 6'd5 || ex_pc !== 32'h0040_0014) begin tests_failed++; $display("[TB] FAIL loaduse_recapture: got v %b dest %0d op %0d pc %h expected 1/7/5/00400014", ex_valid, ex_dest, ex_opcode, ex_pc); end
    tests_run++;
    if (stall_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL loaduse_err: got %b expected 0", stall_err); end
  endtask

  task automatic test_flush_with_stall();
    set_id(6'd7, 5'd3, 32'h0000_0303, 32'h0000_0404, 32'h0000_0020, 32'h0040_0030);
    id_rt_stall = 1'b1;
    tick();
    tests_run++;
    if (dut.u_stall_monitor.stall_run_q !== 2'd1) begin tests_failed++; $display("[TB] FAIL flush_prerun: got %0d expected 1", dut.u_stall_monitor.stall_run_q); end
    flush = 1'b1;
    #1;
    tests_run++;
    if (hold_id !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_hold: got %b expected 0", hold_id); end
    tick();
    tests_run++;
    if (ex_valid !== 1'b0 || ex_dest !== 5'd0 || ex_pc !== 32'd0) begin tests_failed++; $display("[TB] FAIL flush_bubble: got v %b dest %0d pc %h expected 0/0/0", ex_valid, ex_dest, ex_pc); end
    tests_run++;
    if (dut.u_stall_monitor.stall_run_q !== 2'd0) begin tests_failed++; $display("[TB] FAIL flush_run: got %0d expected 0", dut.u_stall_monitor.stall_run_q); end
    // Flush alone with a valid ID instruction still squashes it.
    id_rt_stall = 1'b0;
    tick();
    tests_run++;
    if (ex_valid !== 1'b0 || ex_opcode !== 6'd0) begin tests_failed++; $display("[TB] FAIL flush_only: got v %b op %0d expected 0/0", ex_valid, ex_opcode); end
    flush = 1'b0;
    tick();
    tests_run++;
    if (ex_valid !== 1'b1 || ex_dest !== 5'd3 || stall_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_resume: got v %b dest %0d err %b expected 1/3/0", ex_valid, ex_dest, stall_err); end
  endtask

  task automatic test_stall_err();
    id_rs_stall = 1'b1;
    tick();
    tests_run++;
    if (stall_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_edge1: got %b expected 0", stall_err); end
    tick();
    tests_run++;
    if (stall_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL err_edge2: got %b expected 1", stall_err); end
    tick();
    id_rs_stall = 1'b0;
    tick();
    tick();
    tests_run++;
    if (stall_err !== 1'b1 || ex_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL err_sticky: got err %b v %b expected 1/1", stall_err, ex_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (stall_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_cleared: got %b expected 0", stall_err); end
  endtask

  task automatic test_reset_mid_stall();
    set_id(6'd21, 5'd17, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_0044, 32'h0040_0100);
    id_rs_stall = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if (ex_valid !== 1'b0 || ex_dest !== 5'd0 || ex_opcode !== 6'd0 || ex_rs_val !== 32'd0 || stall_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL rststall_outputs: got v %b dest %0d op %0d rs %h err %b expected zeros", ex_valid, ex_dest, ex_opcode, ex_rs_val, stall_err); end
    tests_run++;
    if (dut.u_stall_monitor.stall_run_q !== 2'd0) begin tests_failed++; $display("[TB] FAIL rststall_run: got %0d expected 0", dut.u_stall_monitor.stall_run_q); end
`ifdef PERF_STALL_COUNT_EN
    tests_run++;
    if (stall_cycles !== 32'd0 || bubbles_flush !== 32'd0) begin tests_failed++; $display("[TB] FAIL rststall_perf: got %0d/%0d expected 0/0", stall_cycles, bubbles_flush); end
`endif
    // First cycle after reset still honours the pending stall.
    rst = 1'b0;
    tick();
    tests_run++;
    if (ex_valid !== 1'b0 || dut.u_stall_monitor.stall_run_q !== 2'd1 || stall_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL postrst_stall: got v %b run %0d err %b expected 0/1/0", ex_valid, dut.u_stall_monitor.stall_run_q, stall_err); end
    id_rs_stall = 1'b0;
    tick();
    tests_run++;
    if (ex_valid !== 1'b1 || ex_dest !== 5'd17 || ex_rt_val !== 32'hCAFE_F00D) begin tests_failed++; $display("[TB] FAIL postrst_capture: got v %b dest %0d rt %h expected 1/17/cafef00d", ex_valid, ex_dest, ex_rt_val); end
  endtask

`ifdef PERF_STALL_COUNT_EN
  task automatic test_perf_counters();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      id_rt_stall = 1'b1;
      tick();
      id_rt_stall = 1'b0;
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
    end
    tests_run++;
    if (stall_cycles !== 32'd5) begin tests_failed++; $display("[TB] FAIL perf_stalls: got %0d expected 5", stall_cycles); end
    tests_run++;
    if (bubbles_flush !== 32'd2) begin tests_failed++; $display("[TB] FAIL perf_flushes: got %0d expected 2", bubbles_flush); end
  endtask
`endif

  initial begin
    rst = 1'b1; flush = 1'b0; id_rs_stall = 1'b0; id_rt_stall = 1'b0;
    set_id(6'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    test_reset();
    test_capture();
    test_back_to_back();
    test_load_use();
    test_flush_with_stall();
    test_stall_err();
    test_reset_mid_stall();
`ifdef PERF_STALL_COUNT_EN
    test_perf_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/id_ex_latch.md
ID_EX_LATCH -- requirements
Module: id_ex_latch

Interface
REQ-001 SHALL: clk  in  1  single pipeline clock; all state updates on rising edge.
REQ-002 SHALL: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL: id_opcode  in  6  decoded internal opcode of the ID instruction.
REQ-004 SHALL: id_dest  in  5  destination register of the ID instruction.
REQ-005 SHALL: id_rs_val, id_rt_val  in  32 each  operand values after forwarding.
REQ-006 SHALL: id_rs_stall, id_rt_stall  in  1 each  load-use stall requests from the two operand forward units.
REQ-007 SHALL: id_imm, id_pc  in  32 each  sign-extended immediate and instruction PC.
REQ-008 SHALL: flush  in  1  branch/jump redirect resolved in EX; squash the ID instruction.
REQ-009 SHALL: ex_opcode 6, ex_dest 5, ex_rs_val 32, ex_rt_val 32, ex_imm 32, ex_pc 32  out  registered EX-stage fields.
REQ-010 SHALL: ex_valid  out  1  registered; 1 = real instruction in EX, 0 = bubble.
REQ-011 SHALL: hold_id  out  1  combinational; 1 = IF/ID and PC must not advance this cycle.
REQ-012 SHALL: stall_err  out  1  registered sticky flag; stall persisted beyond the legal limit.

Function
REQ-013 SHALL: stall_req = id_rs_stall | id_rt_stall; hold_id = stall_req & ~flush.
REQ-014 SHALL: priority per edge: rst > flush > stall_req > capture.
REQ-015 SHALL: on flush, EX loads a bubble regardless of stall_req; hold_id = 0.
REQ-016 SHALL: on stall_req without flush, EX loads a bubble; ID contents are held upstream via hold_id.
REQ-017 SHALL: otherwise EX captures all id_* fields with ex_valid = 1; latency ID->EX exactly one cycle.
REQ-018 SHALL: bubble = opcode OP_NOP (0), dest 0, all value fields 0, ex_valid 0; dest 0 guarantees no downstream forward match.
REQ-019 SHALL: a 2-bit saturating counter stall_run increments on each cycle with hold_id = 1 and clears on any cycle with hold_id = 0.
REQ-020 SHALL: load-use stall lasts at most 1 consecutive cycle; if stall_run reaches 2, stall_err sets next edge and stays set until rst.
REQ-021 SHALL: flush simultaneous with stall clears stall_run (hold_id = 0 that cycle).

Reset
REQ-022 SHALL: on rst, EX fields take bubble values, ex_valid = 0, stall_run = 0, stall_err = 0, stall counter = 0.
REQ-023 SHALL: rst asserted mid-stall or mid-flush overrides both; first post-reset cycle behaves per REQ-014.

Configuration
REQ-024 SHALL: macro PERF_STALL_COUNT_EN, when defined, adds output stall_cycles (32, out) counting cycles with hold_id = 1 and bubbles_flush (32, out) counting flush cycles, both wrapping at 2^32.
REQ-025 SHALL: without PERF_STALL_COUNT_EN, those ports and counters do not exist; all other behaviour identical.

Structure
REQ-026 SHALL: shared package holds OP_NOP, opcode/register/word widths, and the EX-field bundle typedef.
REQ-027 SHALL: one sub-module, stall_monitor, implements stall_run, stall_err and the optional perf counters.

Verification
REQ-028 SHALL: capture: id_opcode=3, id_dest=31, id_pc=0x0040_0010, no stall/flush -> next edge ex_opcode=3, ex_dest=31, ex_pc=0x0040_0010, ex_valid=1.
REQ-029 SHALL: load-use: id_rs_stall=1 one cycle -> hold_id=1 that cycle, next edge ex_valid=0, ex_dest=0; following cycle captures ID normally, stall_err=0.
REQ-030 SHALL: flush with id_rt_stall=1 same cycle -> hold_id=0, bubble in EX, stall_run=0.
REQ-031 SHALL: id_rs_stall held 3 cycles -> stall_err=1 after 2nd stalled edge, remains 1 until rst.
REQ-032 SHALL: rst asserted during stall -> next edge all outputs bubble/zero, stall_err=0; with PERF_STALL_COUNT_EN, stall_cycles=0.
REQ-033 SHALL: with PERF_STALL_COUNT_EN, 5 stall cycles and 2 flush cycles -> stall_cycles=5, bubbles_flush=2.
